// File: rtl/conv_mac_if.sv
// conv_mac_if: handshake bundle between the window/weight fetch logic
// (master) and the dot-product engine conv_mac_seq (slave).
//
// Signals:
//   start      master->slave  begin a dot product (sampled only when idle)
//   bias       master->slave  bias latched on an accepted start
//   in_valid   master->slave  in_data/in_weight carry a pair
//   in_ready   slave->master  engine accepts a pair this cycle
//   in_data    master->slave  activation
//   in_weight  master->slave  weight
//   out_valid  slave->master  out_data holds a finished result
//   out_ready  master->slave  downstream accepts the result
//   out_data   slave->master  result
//   busy       slave->master  engine is not idle
interface conv_mac_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_weight;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport master (
    output start, bias, in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential multiply-accumulate engine for one convolution
// output pixel. A job latches a bias on start, then consumes TAPS
// (activation, weight) pairs over a valid/ready handshake and presents
// bias + sum(in*w) on a valid/ready result port.
//
// All arithmetic is unsigned and wraps modulo 2^DATA_W: product bits above
// DATA_W-1 are dropped and every addition wraps, with no saturation.
//
// Ports:
//   clk  clock, all logic on the rising edge
//   rst  synchronous active-high reset; overrides everything, drops any
//        partial accumulation or pending result
//   bus  conv_mac_if.slave (start/bias, input pair stream, result stream,
//        busy)
//
// Every output is a register or a decode of the state register, so there
// is no combinational path from any input to any output.
module conv_mac_seq #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 9
) (
  input  logic        clk,
  input  logic        rst,
  conv_mac_if.slave   bus
);

  localparam int CNT_W = $clog2(TAPS) + 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Low DATA_W bits of the full product.
  function automatic logic [DATA_W-1:0] trunc_prod(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return full[DATA_W-1:0];
  endfunction

  // Modulo-2^DATA_W addition; the carry is discarded on purpose.
  function automatic logic [DATA_W-1:0] wrap_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[DATA_W-1:0];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] sum;

  assign prod = trunc_prod(bus.in_data, bus.in_weight);
  assign sum  = wrap_add(acc_q, prod);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.bias;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        // in_ready is 1 throughout ACC, so in_valid alone marks a handshake.
        if (bus.in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_TAP) begin
            result_d = sum;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start is not looked at here, so a start coinciding with the
        // result handshake is dropped rather than queued.
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_data  = result_q;

endmodule
